ber_sync_checker: RTL
=====================

Name: ber_sync_checker

Overview:
- Bit-error-rate checker with automatic delay alignment. Sits at the tail of each QPSK receive branch (one instance per I and Q), downstream of the slicer.
- Compares received hard bits against the local PRBS reference. Searches for the reference delay that aligns the two streams, then accumulates error and total bit counts.
- Outputs feed the register file's error/bit accumulator inputs and the sync-done / BER-ok LEDs.

Parameters:
- N_DELAY, 512, number of reference delay taps searched (0..N_DELAY-1).
- NBT_COUNT_BITS_ERR, 64, width of the error and total accumulators.
- SYNC_WIN, 256, valid samples per evaluation window.
- SYNC_ERR_MAX, 8, maximum window errors accepted for lock.
- LOSS_ERR_MIN, 64, window errors at or above this value drop lock.
- BER_OK_ERR_MAX, 2, maximum window errors for BER-ok.

Ports:
- clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  symbol-rate strobe; one bit pair per strobe.
- i_enable  in  1  receive enable; effective strobe is i_valid && i_enable.
- i_rx_bit  in  1  received hard-decision bit.
- i_ref_bit  in  1  local PRBS reference bit.
- o_accum_err  out  NBT_COUNT_BITS_ERR  accumulated bit errors.
- o_accum_tot  out  NBT_COUNT_BITS_ERR  accumulated compared bits.
- o_sync_done  out  1  aligned/locked.
- o_ber_ok  out  1  last locked window within BER_OK_ERR_MAX.
- o_delay  out  $clog2(N_DELAY)  current delay tap.

Behaviour:
- Reset (asynchronous, active-high) clears all state: state=SEARCH, delay line, window counters, every output = 0.
- Strobe: s = i_valid && i_enable. Nothing changes on cycles with s=0 (state, counters and delay line all hold).
- Delay line:
  - On s, shift register shreg <= {shreg[N_DELAY-2:0], i_ref_bit}.
  - Tap(0) = i_ref_bit (combinational); Tap(d) = shreg[d-1].
  - err = i_rx_bit ^ Tap(o_delay).
  - The line is zero-filled after reset; this is not treated as special.
- Window:
  - win_cnt runs 0..SYNC_WIN-1 on s. win_err accumulates err.
  - Window end is s && win_cnt==SYNC_WIN-1. The total used for decisions is wtot = win_err + err (current sample included).
  - At window end, win_cnt and win_err both return to 0.
- State SEARCH, at window end:
  - If wtot <= SYNC_ERR_MAX: go to LOCKED, o_sync_done=1 next cycle, o_delay unchanged.
  - Else o_delay <= (o_delay==N_DELAY-1) ? 0 : o_delay+1.
  - Accumulators do not change in SEARCH.
- State LOCKED, on every s:
  - o_accum_tot += 1, o_accum_err += err.
  - Each accumulator saturates independently at all-ones and holds there.
- State LOCKED, at window end:
  - o_ber_ok <= (wtot <= BER_OK_ERR_MAX).
  - If wtot >= LOSS_ERR_MIN: go to SEARCH, o_sync_done=0, o_ber_ok=0, o_delay advances by one with wrap. Accumulators hold their values.
  - If the loss and BER-ok conditions are evaluated in the same window, loss takes priority.
- Latency: all outputs are registered and reflect strobe k on the cycle after it.
- Reset mid-window or mid-lock: immediate clear; no partial window is carried over.
- i_enable deasserted mid-window: the window pauses and resumes when i_enable returns.

Optional Feature:
- Macro: BER_SYNC_CHECKER_CLEAR_EN.
- Defined: adds input port i_clear (1 bit). i_clear=1 synchronously zeroes o_accum_err and o_accum_tot on the next edge and has priority over accumulation on the same cycle. State, delay and window are untouched.
- Undefined: the port is absent and accumulators clear only on i_reset.

Test Plan:
1. Lock search: PRBS9 reference; rx = reference delayed 37 strobes, no errors; continuous s -> o_sync_done rises after 38*256 strobes, o_delay=37, o_accum_tot=0 at that point.
2. Counting: after lock, 10000 strobes with one inverted rx bit every 1000 -> o_accum_tot=10000, o_accum_err=10, o_ber_ok=1.
3. Loss of lock: after lock, invert every rx bit for one full window -> o_sync_done=0, o_ber_ok=0, o_delay=38, accumulators frozen at their pre-window values plus that window's counts.
4. Saturation: NBT_COUNT_BITS_ERR=8, LOSS_ERR_MIN=SYNC_WIN+1; lock, then 300 all-error strobes -> o_accum_err=255 and holds; o_accum_tot=255.
5. Gating: after lock, toggle i_valid at 1/4 rate with i_enable low for 100 cycles -> no output changes; restore i_enable -> counting resumes exactly from held values.
6. Async reset: assert i_reset mid-window while LOCKED, between clock edges -> all outputs 0 immediately; with BER_SYNC_CHECKER_CLEAR_EN, an i_clear pulse -> accumulators 0, o_sync_done stays 1.

Source files
------------

// File: rtl/ber_sync_checker.sv
// rtl/ber_sync_checker.sv - BER checker that searches the PRBS reference delay, locks, then accumulates errors.
// Optional accumulator clear port i_clear is enabled by defining BER_SYNC_CHECKER_CLEAR_EN.
module ber_sync_checker #(
  parameter int N_DELAY            = 512,
  parameter int NBT_COUNT_BITS_ERR = 64,
  parameter int SYNC_WIN           = 256,
  parameter int SYNC_ERR_MAX       = 8,
  parameter int LOSS_ERR_MIN       = 64,
  parameter int BER_OK_ERR_MAX     = 2
) (
  input  logic                          clk,
  input  logic                          i_reset,
`ifdef BER_SYNC_CHECKER_CLEAR_EN
  input  logic                          i_clear,
`endif
  input  logic                          i_valid,
  input  logic                          i_enable,
  input  logic                          i_rx_bit,
  input  logic                          i_ref_bit,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_err,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_tot,
  output logic                          o_sync_done,
  output logic                          o_ber_ok,
  output logic [$clog2(N_DELAY)-1:0]    o_delay
);

  localparam int DW = $clog2(N_DELAY);
  localparam int CW = $clog2(SYNC_WIN);
  localparam int EW = $clog2(SYNC_WIN + 1);
  localparam int NW = NBT_COUNT_BITS_ERR;

  localparam logic [31:0] SYNC_ERR_MAX_U   = SYNC_ERR_MAX;
  localparam logic [31:0] LOSS_ERR_MIN_U   = LOSS_ERR_MIN;
  localparam logic [31:0] BER_OK_ERR_MAX_U = BER_OK_ERR_MAX;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [N_DELAY-2:0]  shreg_q, shreg_d;
  logic [CW-1:0]       win_cnt_q, win_cnt_d;
  logic [EW-1:0]       win_err_q, win_err_d;
  logic [DW-1:0]       delay_q, delay_d;
  logic [NW-1:0]       acc_err_q, acc_err_d;
  logic [NW-1:0]       acc_tot_q, acc_tot_d;
  logic                sync_q, sync_d;
  logic                ber_ok_q, ber_ok_d;

  logic                strobe;
  logic [N_DELAY-1:0]  taps;
  logic                err;
  logic                win_end;
  logic [EW-1:0]       wtot;
  logic [31:0]         wtot32;
  logic [DW-1:0]       delay_inc;

  // Tap 0 is the live reference bit, tap d is the bit seen d strobes ago.
  assign strobe    = i_valid && i_enable;
  assign taps      = {shreg_q, i_ref_bit};
  assign err       = i_rx_bit ^ taps[delay_q];
  assign win_end   = strobe && (win_cnt_q == CW'(SYNC_WIN - 1));
  assign wtot      = win_err_q + EW'(err);
  assign wtot32    = 32'(wtot);
  assign delay_inc = (delay_q == DW'(N_DELAY - 1)) ? '0 : delay_q + DW'(1);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    delay_d   = delay_q;
    acc_err_d = acc_err_q;
    acc_tot_d = acc_tot_q;
    sync_d    = sync_q;
    ber_ok_d  = ber_ok_q;

    if (strobe) begin
      shreg_d = {shreg_q[N_DELAY-3:0], i_ref_bit};
      if (win_end) begin
        win_cnt_d = '0;
        win_err_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + CW'(1);
        win_err_d = wtot;
      end

      case (state_q)
        SEARCH: begin
          if (win_end) begin
            if (wtot32 <= SYNC_ERR_MAX_U) begin
              state_d = LOCKED;
              sync_d  = 1'b1;
            end else begin
              delay_d = delay_inc;
            end
          end
        end
        LOCKED: begin
          // Both accumulators stick at all-ones rather than wrapping.
          if (acc_tot_q != '1) acc_tot_d = acc_tot_q + NW'(1);
          if (err && (acc_err_q != '1)) acc_err_d = acc_err_q + NW'(1);
          if (win_end) begin
            if (wtot32 >= LOSS_ERR_MIN_U) begin
              state_d  = SEARCH;
              sync_d   = 1'b0;
              ber_ok_d = 1'b0;
              delay_d  = delay_inc;
            end else begin
              ber_ok_d = (wtot32 <= BER_OK_ERR_MAX_U);
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

`ifdef BER_SYNC_CHECKER_CLEAR_EN
    if (i_clear) begin
      acc_err_d = '0;
      acc_tot_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= SEARCH;
      shreg_q   <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      delay_q   <= '0;
      acc_err_q <= '0;
      acc_tot_q <= '0;
      sync_q    <= 1'b0;
      ber_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      delay_q   <= delay_d;
      acc_err_q <= acc_err_d;
      acc_tot_q <= acc_tot_d;
      sync_q    <= sync_d;
      ber_ok_q  <= ber_ok_d;
    end
  end

  assign o_accum_err = acc_err_q;
  assign o_accum_tot = acc_tot_q;
  assign o_sync_done = sync_q;
  assign o_ber_ok    = ber_ok_q;
  assign o_delay     = delay_q;

endmodule
